// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encoding for the nibble-slice ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ADD_OP = 3'd0;
  localparam logic [ALU_OP_W-1:0] ADC_OP = 3'd1;
  localparam logic [ALU_OP_W-1:0] SUB_OP = 3'd2;
  localparam logic [ALU_OP_W-1:0] SBC_OP = 3'd3;
  localparam logic [ALU_OP_W-1:0] AND_OP = 3'd4;
  localparam logic [ALU_OP_W-1:0] XOR_OP = 3'd5;
  localparam logic [ALU_OP_W-1:0] OR_OP  = 3'd6;
  localparam logic [ALU_OP_W-1:0] CP_OP  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : alu_addsub
//  Description : WIDTH-bit adder/subtractor. With sub=1 it computes
//                a - b - cin and reports a borrow; with sub=0 it computes
//                a + b + cin and reports a carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   total;

  // Subtraction is a + ~b + ~borrow_in; the raw carry-out is then the
  // complement of the borrow, so it is flipped back for the caller.
  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub ? ~cin : cin;
    total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    sum   = total[WIDTH-1:0];
    cout  = sub ? ~total[WIDTH] : total[WIDTH];
  end

endmodule
`default_nettype wire

// File: rtl/alu_nibble.sv
`default_nettype none
// ============================================================================
//  Module      : alu_nibble
//  Description : Chainable WIDTH-bit ALU slice with combinational result and
//                zero/carry flags, plus a load-enabled flag register copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_A,
  input  logic [WIDTH-1:0]    in_B,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic                in_C,
  output logic [WIDTH-1:0]    out,
  output logic                out_Z,
  output logic                out_C,
  input  logic                flags_we,
  output logic [WIDTH-1:0]    out_q,
  output logic                out_Z_q,
  output logic                out_C_q
);

  logic             as_sub;
  logic             as_cin;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;

  // Select add vs subtract and whether the chained carry/borrow is used.
  always_comb begin
    as_sub = (alu_op == SUB_OP) || (alu_op == SBC_OP) || (alu_op == CP_OP);
    as_cin = ((alu_op == ADC_OP) || (alu_op == SBC_OP) || (alu_op == CP_OP)) ? in_C : 1'b0;
  end

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a    (in_A),
    .b    (in_B),
    .cin  (as_cin),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  // Result/flag mux; CP passes A through but takes Z from the difference.
  always_comb begin
    out   = '0;
    out_C = 1'b0;
    out_Z = 1'b0;
    case (alu_op)
      ADD_OP, ADC_OP, SUB_OP, SBC_OP: begin
        out   = as_sum;
        out_C = as_cout;
      end
      AND_OP: out = in_A & in_B;
      XOR_OP: out = in_A ^ in_B;
      OR_OP:  out = in_A | in_B;
      CP_OP: begin
        out   = in_A;
        out_C = as_cout;
      end
      default: begin
        out   = '0;
        out_C = 1'b0;
      end
    endcase
    out_Z = (alu_op == CP_OP) ? (as_sum == '0) : (out == '0);
  end

  // Flag register: reset wins over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      out_Z_q <= 1'b0;
      out_C_q <= 1'b0;
    end else if (flags_we) begin
      out_q   <= out;
      out_Z_q <= out_Z;
      out_C_q <= out_C;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_nibble
//  Description : Scoreboard bench for alu_nibble against an integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_nibble;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_A, in_B;
  logic [2:0]   alu_op;
  logic         in_C;
  logic         flags_we;
  logic [W-1:0] out, out_q;
  logic         out_Z, out_C, out_Z_q, out_C_q;

  alu_nibble #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_A     (in_A),
    .in_B     (in_B),
    .alu_op   (alu_op),
    .in_C     (in_C),
    .out      (out),
    .out_Z    (out_Z),
    .out_C    (out_C),
    .flags_we (flags_we),
    .out_q    (out_q),
    .out_Z_q  (out_Z_q),
    .out_C_q  (out_C_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a, b, op, ci;
    int o, z, c;
    int q, zq, cq;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model register state and the inputs applied during the previous cycle.
  int m_q = 0, m_zq = 0, m_cq = 0;
  int p_rst = 1, p_we = 0, p_o = 0, p_z = 0, p_c = 0;

  // Reference behaviour straight from the opcode rules, in plain integers.
  function automatic void ref_alu(input int a, b, op, ci, output int o, z, c);
    int t;
    o = 0; z = 0; c = 0;
    case (op)
      0: begin t = a + b;      o = t & MASK; c = (t > MASK); end
      1: begin t = a + b + ci; o = t & MASK; c = (t > MASK); end
      2: begin t = a - b;      o = t & MASK; c = (t < 0);    end
      3: begin t = a - b - ci; o = t & MASK; c = (t < 0);    end
      4: o = a & b;
      5: o = a ^ b;
      6: o = a | b;
      default: begin t = a - b - ci; o = a; c = (t < 0); z = ((t & MASK) == 0); end
    endcase
    if (op != 7) z = (o == 0);
  endfunction

  task automatic apply(input int a, b, op, ci, we, r);
    exp_t e;
    @(posedge clk);
    if (p_rst != 0) begin
      m_q = 0; m_zq = 0; m_cq = 0;
    end else if (p_we != 0) begin
      m_q = p_o; m_zq = p_z; m_cq = p_c;
    end
    #1;
    in_A = W'(a); in_B = W'(b); alu_op = 3'(op); in_C = ci[0];
    flags_we = we[0]; rst = r[0];
    e.a = a; e.b = b; e.op = op; e.ci = ci;
    ref_alu(a, b, op, ci, e.o, e.z, e.c);
    e.q = m_q; e.zq = m_zq; e.cq = m_cq;
    sb.push_back(e);
    p_rst = r; p_we = we; p_o = e.o; p_z = e.z; p_c = e.c;
  endtask

  task automatic chk(input string name, input int act, input int req, input exp_t e);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s op=%0d A=%h B=%h C=%0d: got %h expected %h", name, e.op, e.a, e.b, e.ci, act, req);
    end
  endtask

  // Monitor: combinational outputs are settled mid-cycle, so compare there.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("out",     int'(out),     e.o,  e);
      chk("out_Z",   int'(out_Z),   e.z,  e);
      chk("out_C",   int'(out_C),   e.c,  e);
      chk("out_q",   int'(out_q),   e.q,  e);
      chk("out_Z_q", int'(out_Z_q), e.zq, e);
      chk("out_C_q", int'(out_C_q), e.cq, e);
    end
  end

  initial begin
    rst = 1'b1; flags_we = 1'b0; in_A = '0; in_B = '0; alu_op = '0; in_C = 1'b0;

    // Reset state and directed cases from the opcode rules.
    apply(0, 0, 0, 0, 0, 1);
    apply('hF, 1, 0, 0, 0, 0);
    apply('hF, 1, 0, 1, 0, 0);
    apply(1, 2, 0, 1, 0, 0);
    apply('hD, 2, 1, 1, 0, 0);
    apply('hF, 2, 1, 1, 0, 0);
    apply(0, 1, 2, 0, 0, 0);
    apply(2, 1, 3, 1, 0, 0);
    apply(0, 1, 3, 1, 0, 0);
    apply('hC, 'hC, 2, 0, 0, 0);
    apply('hC, 9, 4, 0, 0, 0);
    apply('hA, 'hC, 5, 0, 0, 0);
    apply('hC, 1, 6, 0, 0, 0);
    apply('hF, 'hF, 4, 1, 0, 0);
    apply('hF, 'hF, 5, 0, 0, 0);
    apply(2, 1, 7, 0, 0, 0);
    apply(2, 1, 7, 1, 0, 0);
    apply(0, 1, 7, 0, 0, 0);
    apply('hC, 'hC, 7, 0, 0, 0);

    // Register load, hold, and reset-over-load.
    apply('hF, 1, 0, 0, 1, 0);
    apply(3, 4, 6, 1, 0, 0);
    apply(7, 2, 2, 0, 0, 0);
    apply(5, 5, 1, 1, 1, 1);
    apply(1, 1, 0, 0, 0, 0);

    // Exhaustive sweep with randomized register control.
    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          for (int c = 0; c < 2; c++)
            apply(a, b, op, c, int'($urandom_range(0, 1)), int'($urandom_range(0, 15) == 0));

    apply(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_nibble.md
Name: alu_nibble

Overview:
- Slice-wide integer ALU: two WIDTH-bit operands, 3-bit opcode, carry/borrow in.
- Produces a combinational result plus zero and carry/borrow flags, so slices can be chained LSB-first through in_C/out_C for wider operations, including multi-slice compare.
- Also holds a registered copy of result and flags for the CPU flag register, loaded on enable.

Parameters:
- WIDTH, 4, operand/result width in bits.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset; clears the registered outputs only.
- in_A  in  WIDTH  operand A (accumulator side).
- in_B  in  WIDTH  operand B.
- alu_op  in  3  operation select.
- in_C  in  1  carry-in (ADC) or borrow-in (SBC, CP); ignored by the other ops.
- out  out  WIDTH  combinational result.
- out_Z  out  1  combinational zero flag.
- out_C  out  1  combinational carry-out / borrow-out.
- flags_we  in  1  load enable for the registered outputs.
- out_q  out  WIDTH  registered result.
- out_Z_q  out  1  registered zero flag.
- out_C_q  out  1  registered carry flag.

Behaviour:
- Opcodes: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP. Put these in a shared package.
- out, out_Z and out_C are purely combinational from in_A, in_B, alu_op and in_C, with zero latency and no dependence on clk or rst.
- ADD: out = (A+B) mod 2^WIDTH; out_C = carry out of the MSB. in_C is ignored.
- ADC: out = (A+B+in_C) mod 2^WIDTH; out_C = carry out.
- SUB: out = (A-B) mod 2^WIDTH; out_C = 1 iff A < B (borrow). in_C is ignored.
- SBC: out = (A-B-in_C) mod 2^WIDTH; out_C = 1 iff A < B+in_C (borrow).
- AND, XOR, OR: bitwise result; out_C = 0 regardless of in_C.
- CP:
  - out = in_A, passed through unchanged.
  - Flags come from the internal difference D = A-B-in_C, computed exactly as SBC: out_Z = (D == 0), out_C = borrow.
  - Borrow-in lets an LSB slice's borrow feed the next slice's compare.
- out_Z: for ops 0–6, out_Z = (out == 0). For CP, out_Z follows D as above, not out.
- Arithmetic is computed at WIDTH+1 bits; bit WIDTH is the carry/borrow.
- Registered outputs:
  - On a rising edge of clk, rst=1 sets out_q=0, out_Z_q=0, out_C_q=0.
  - Otherwise, flags_we=1 loads out, out_Z and out_C into them; flags_we=0 holds them.
  - rst has priority over flags_we.
- Reset mid-operation affects only the registers; combinational outputs stay valid.
- No X propagation: every opcode value is decoded and there is no default-X branch.

Decomposition:
- Package alu_pkg holds the opcode localparams (ADD_OP…CP_OP) and the ALU_OP_W=3 constant.
- One natural sub-module, alu_addsub: a WIDTH-bit adder/subtractor with carry-in and invert-B control, shared by ADD, ADC, SUB, SBC and CP.
- Logic ops, result/flag mux and the output register live in the top module.

Test Plan:
- ADD/ADC:
  - ADD with A=F, B=1, C=0/1 -> out=0, Z=1, C=1.
  - ADD with A=1, B=2, C=1 -> out=3, C=0 (in_C ignored).
  - ADC with A=D, B=2, C=1 -> out=0, Z=1, C=1.
  - ADC with A=F, B=2, C=1 -> out=2, C=1.
- SUB/SBC:
  - SUB with A=0, B=1 -> out=F, C=1, Z=0.
  - SBC with A=2, B=1, C=1 -> out=0, Z=1, C=0.
  - SBC with A=0, B=1, C=1 -> out=E, C=1.
  - SUB with A=C, B=C -> out=0, Z=1, C=0.
- Logic:
  - AND with A=C, B=9 -> out=8.
  - XOR with A=A, B=C -> out=6.
  - OR with A=C, B=1 -> out=D.
  - AND with A=F, B=F, C=1 -> out=F, C=0.
  - XOR with A=F, B=F -> out=0, Z=1.
- CP:
  - A=2, B=1, C=0 -> out=2, Z=0, C=0.
  - A=2, B=1, C=1 -> out=2, Z=1, C=0.
  - A=0, B=1, C=0 -> out=0, Z=0, C=1.
  - A=C, B=C, C=0 -> out=C, Z=1, C=0.
- Registers:
  - Assert rst -> out_q, Z_q, C_q = 0.
  - ADD F+1 with flags_we=1 for one edge -> out_q=0, Z_q=1, C_q=1.
  - Change operands with flags_we=0 -> registered outputs hold.
  - Assert rst and flags_we together -> cleared.
- Sweep: all 8 ops × all A, B, C combinations are compared against a behavioural model, with the combinational outputs checked at zero latency.
